// File: rtl/flash_burst_ctrl.sv
// Flash burst controller.
// Memory-mapped front end for the SPI flash engine. Software programs
// ADDRESS/LENGTH/WDATA and kicks a read burst or a single-word write through
// CONTROL. The controller issues one-word req/ack/done transactions to the
// engine and buffers read words in a small FIFO drained through RDATA.
//
// Ports:
//   clk, reset          system clock, async active-low reset
//   ren, wen            one-cycle bus read / write strobes
//   address, data_in    register byte offset and write data
//   data_out            registered read data (1-cycle latency)
//   irq                 level interrupt = done_flag & irq_en
//   eng_req/eng_write/eng_addr/eng_wdata   request to the flash engine
//   eng_ack/eng_done/eng_rdata             engine handshake and read data
//
// state  | meaning
// IDLE   | no command in flight
// ISSUE  | presenting a request; read requests stall while the FIFO is full
// WAIT   | request accepted, waiting for eng_done
// FINISH | advance ADDRESS, raise done_flag
module flash_burst_ctrl #(
    parameter int                ADDR_W      = 24,
    parameter logic [ADDR_W-1:0] BASE_OFFSET = 24'h500000,
    parameter int                FIFO_DEPTH  = 8,
    parameter int                LEN_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ren,
    input  logic              wen,
    input  logic [7:0]        address,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              irq,
    output logic              eng_req,
    output logic              eng_write,
    output logic [ADDR_W-1:0] eng_addr,
    output logic [31:0]       eng_wdata,
    input  logic              eng_ack,
    input  logic              eng_done,
    input  logic [31:0]       eng_rdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [7:0] REG_STATUS  = 8'h00;
    localparam logic [7:0] REG_CONTROL = 8'h04;
    localparam logic [7:0] REG_ADDRESS = 8'h08;
    localparam logic [7:0] REG_WDATA   = 8'h0C;
    localparam logic [7:0] REG_RDATA   = 8'h10;
    localparam logic [7:0] REG_LENGTH  = 8'h14;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  cnt;
    logic              cmd_write;
    logic              irq_en;
    logic              done_flag;
    logic              err_flag;

    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;

    // ------------------------------------------------------------------
    // Bus decode. A simultaneous read and write is treated as a write only.
    // ------------------------------------------------------------------
    logic wr_acc, rd_acc, busy, fifo_empty, fifo_full;
    logic ctrl_wr, start_rd_cmd, start_wr_cmd, cmd_conflict;
    logic start_read, start_write, zero_len_done;
    logic flush_req, flush, flush_err, cfg_wr, cfg_err;
    logic pop_req, pop, empty_rd_err, push;
    logic err_set, done_set, flag_clr;
    logic [LEN_W-1:0]  cnt_inc;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] addr_step;
    logic [31:0]       rd_mux;

    assign wr_acc     = wen;
    assign rd_acc     = ren & ~wen;
    assign busy       = (state != S_IDLE);
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));

    assign ctrl_wr       = wr_acc & (address == REG_CONTROL);
    assign start_rd_cmd  = ctrl_wr & data_in[0];
    assign start_wr_cmd  = ctrl_wr & data_in[1];
    assign cmd_conflict  = (start_rd_cmd & start_wr_cmd) |
                           ((start_rd_cmd | start_wr_cmd) & busy);
    assign start_read    = start_rd_cmd & ~cmd_conflict & (len_reg != '0);
    assign zero_len_done = start_rd_cmd & ~cmd_conflict & (len_reg == '0);
    assign start_write   = start_wr_cmd & ~cmd_conflict;

    assign flush_req = ctrl_wr & data_in[3];
    assign flush     = flush_req & ~busy;
    assign flush_err = flush_req & busy;

    assign cfg_wr  = wr_acc & ((address == REG_ADDRESS) |
                               (address == REG_WDATA) |
                               (address == REG_LENGTH));
    assign cfg_err = cfg_wr & busy;

    assign pop_req      = rd_acc & (address == REG_RDATA);
    assign pop          = pop_req & ~fifo_empty;
    assign empty_rd_err = pop_req & fifo_empty;
    assign push         = (state == S_WAIT) & eng_done & ~cmd_write;

    assign err_set  = cmd_conflict | flush_err | cfg_err | empty_rd_err;
    assign done_set = zero_len_done | (state == S_FINISH);
    assign flag_clr = ctrl_wr & data_in[2];

    assign cnt_inc   = cnt + 1'b1;
    assign req_addr  = BASE_OFFSET + addr_reg + ADDR_W'({cnt, 2'b00});
    assign addr_step = cmd_write ? ADDR_W'(4) : ADDR_W'({len_reg, 2'b00});

    assign irq = done_flag & irq_en;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        logic issue_ok;
        state_nxt = state;
        eng_req   = 1'b0;
        eng_write = 1'b0;
        eng_addr  = '0;
        eng_wdata = '0;
        // A read may only be requested when its word is guaranteed a FIFO slot.
        issue_ok  = cmd_write | ~fifo_full;
        case (state)
            S_IDLE: begin
                if (start_read || start_write) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                eng_req   = issue_ok;
                eng_write = cmd_write;
                eng_addr  = req_addr;
                eng_wdata = cmd_write ? wdata_reg : '0;
                if (issue_ok && eng_ack) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (eng_done) begin
                    if (cmd_write || (cnt_inc == len_reg)) begin
                        state_nxt = S_FINISH;
                    end else begin
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_FINISH: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register file and command context
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_reg  <= '0;
            wdata_reg <= '0;
            len_reg   <= '0;
            cnt       <= '0;
            cmd_write <= 1'b0;
            irq_en    <= 1'b0;
            done_flag <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            if (state == S_FINISH) begin
                addr_reg <= addr_reg + addr_step;
            end else if (wr_acc && !busy && address == REG_ADDRESS) begin
                addr_reg <= data_in[ADDR_W-1:0];
            end

            if (wr_acc && !busy && address == REG_WDATA) begin
                wdata_reg <= data_in;
            end

            if (wr_acc && !busy && address == REG_LENGTH) begin
                len_reg <= data_in[LEN_W-1:0];
            end

            if (ctrl_wr) begin
                irq_en <= data_in[4];
            end

            if (start_read) begin
                cmd_write <= 1'b0;
                cnt       <= '0;
            end else if (start_write) begin
                cmd_write <= 1'b1;
                cnt       <= '0;
            end else if (push) begin
                cnt <= cnt_inc;
            end

            // Set wins over a clear landing in the same cycle.
            done_flag <= done_set | (done_flag & ~flag_clr);
            err_flag  <= err_set | (err_flag & ~flag_clr);
        end
    end

    // ------------------------------------------------------------------
    // Read FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= eng_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + 1'b1;
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux and registered bus data
    // ------------------------------------------------------------------
    always_comb begin
        rd_mux = '0;
        case (address)
            REG_STATUS: begin
                rd_mux[0]    = busy;
                rd_mux[1]    = fifo_empty;
                rd_mux[2]    = fifo_full;
                rd_mux[3]    = done_flag;
                rd_mux[4]    = err_flag;
                rd_mux[5]    = irq_en;
                rd_mux[15:8] = 8'(fifo_cnt);
            end
            REG_CONTROL: rd_mux[4] = irq_en;
            REG_ADDRESS: rd_mux[ADDR_W-1:0] = addr_reg;
            REG_WDATA:   rd_mux = wdata_reg;
            REG_RDATA:   rd_mux = fifo_empty ? 32'hDEADBEEF : fifo_mem[rd_ptr];
            REG_LENGTH:  rd_mux[LEN_W-1:0] = len_reg;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
        end else if (rd_acc) begin
            data_out <= rd_mux;
        end
    end

endmodule

// File: tb/tb_flash_burst_ctrl.sv
module tb_flash_burst_ctrl;

    localparam int          DEPTH = 8;
    localparam logic [23:0] BASE  = 24'h500000;
    localparam logic [7:0]  A_STATUS = 8'h00, A_CTRL = 8'h04, A_ADDR = 8'h08;
    localparam logic [7:0]  A_WDATA  = 8'h0C, A_RDATA = 8'h10, A_LEN = 8'h14;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ren = 1'b0, wen = 1'b0;
    logic [7:0]  address = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        irq;
    logic        eng_req, eng_write;
    logic [23:0] eng_addr;
    logic [31:0] eng_wdata;
    logic        eng_ack = 1'b0, eng_done = 1'b0;
    logic [31:0] eng_rdata = '0;

    flash_burst_ctrl #(
        .ADDR_W(24), .BASE_OFFSET(24'h500000), .FIFO_DEPTH(DEPTH), .LEN_W(8)
    ) dut (
        .clk(clk), .reset(reset), .ren(ren), .wen(wen), .address(address),
        .data_in(data_in), .data_out(data_out), .irq(irq),
        .eng_req(eng_req), .eng_write(eng_write), .eng_addr(eng_addr),
        .eng_wdata(eng_wdata), .eng_ack(eng_ack), .eng_done(eng_done),
        .eng_rdata(eng_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model of the software-visible state.
    logic [23:0] m_addr, m_addr_next;
    logic [31:0] m_wdata;
    logic [7:0]  m_len;
    bit          m_irq_en, m_done, m_err, m_busy;
    logic [31:0] m_fifo[$];
    logic [23:0] exp_addr_q[$];
    bit          exp_write_q[$];
    logic [31:0] exp_wdata_q[$];
    logic [23:0] addr_log[$];
    logic [31:0] wdata_log[$];
    int          n_issued = 0, n_done = 0;
    int          ack_max = 2, done_max = 3, hang_at = -1;
    bit          hung = 0, late_go = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_addr = '0; m_addr_next = '0; m_wdata = '0; m_len = '0;
        m_irq_en = 0; m_done = 0; m_err = 0; m_busy = 0;
        m_fifo.delete(); exp_addr_q.delete(); exp_write_q.delete(); exp_wdata_q.delete();
    endtask

    task automatic model_read(input logic [7:0] a, output logic [31:0] exp);
        case (a)
            A_STATUS: exp = {16'h0, 8'(m_fifo.size()), 2'b00, m_irq_en, m_err, m_done,
                             m_fifo.size() == DEPTH, m_fifo.size() == 0, m_busy};
            A_CTRL:   exp = {27'h0, m_irq_en, 4'h0};
            A_ADDR:   exp = {8'h0, m_addr};
            A_WDATA:  exp = m_wdata;
            A_LEN:    exp = {24'h0, m_len};
            A_RDATA: begin
                if (m_fifo.size() == 0) begin
                    exp = 32'hDEADBEEF;
                    m_err = 1;
                end else begin
                    exp = m_fifo.pop_front();
                end
            end
            default:  exp = '0;
        endcase
    endtask

    task automatic model_write(input logic [7:0] a, input logic [31:0] d);
        logic [23:0] t;
        case (a)
            A_CTRL: begin
                m_irq_en = d[4];
                if (d[2]) begin m_done = 0; m_err = 0; end
                if (d[3]) begin
                    if (m_busy) m_err = 1;
                    else m_fifo.delete();
                end
                if (d[0] || d[1]) begin
                    if ((d[0] && d[1]) || m_busy) begin
                        m_err = 1;
                    end else if (d[0]) begin
                        if (m_len == 0) begin
                            m_done = 1;
                        end else begin
                            for (int i = 0; i < int'(m_len); i++) begin
                                t = BASE + m_addr + 24'(4 * i);
                                exp_addr_q.push_back(t);
                                exp_write_q.push_back(0);
                                exp_wdata_q.push_back('0);
                            end
                            m_addr_next = m_addr + 24'(4 * int'(m_len));
                            m_busy = 1;
                        end
                    end else begin
                        t = BASE + m_addr;
                        exp_addr_q.push_back(t);
                        exp_write_q.push_back(1);
                        exp_wdata_q.push_back(m_wdata);
                        m_addr_next = m_addr + 24'd4;
                        m_busy = 1;
                    end
                end
            end
            A_ADDR:  if (m_busy) m_err = 1; else m_addr = d[23:0];
            A_WDATA: if (m_busy) m_err = 1; else m_wdata = d;
            A_LEN:   if (m_busy) m_err = 1; else m_len = d[7:0];
            default: ;
        endcase
    endtask

    // Bus tasks: called at a negedge, return at the next negedge.
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        model_write(a, d);
        wen = 1; address = a; data_in = d;
        @(negedge clk);
        wen = 0;
    endtask

    task automatic bus_read(input logic [7:0] a, input string name);
        logic [31:0] exp;
        model_read(a, exp);
        ren = 1; address = a;
        @(negedge clk);
        ren = 0;
        check(name, data_out, exp);
    endtask

    task automatic bus_read_raw(input logic [7:0] a, output logic [31:0] d);
        ren = 1; address = a;
        @(negedge clk);
        ren = 0;
        d = data_out;
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] s;
        bit ok;
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            bus_read_raw(A_STATUS, s);
            if (!s[0]) begin ok = 1; break; end
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: busy still 1 after 500 polls, expected 0", name);
        end
        if (m_busy) begin
            m_busy = 0; m_done = 1; m_addr = m_addr_next;
        end
        check({name, "_all_reqs"}, exp_addr_q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_data_out"}, data_out, 0);
        check({name, "_irq"}, irq, 0);
        check({name, "_eng_req"}, eng_req, 0);
        check({name, "_eng_write"}, eng_write, 0);
        check({name, "_eng_addr"}, eng_addr, 0);
        check({name, "_eng_wdata"}, eng_wdata, 0);
    endtask

    // Flash engine: checks every request against the model and answers it.
    initial begin : engine
        logic [23:0] a, ea;
        logic [31:0] r, ed;
        bit w, ew;
        int d;
        forever begin
            @(negedge clk);
            if (reset && eng_req) begin
                a = eng_addr; w = eng_write;
                if (exp_addr_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL eng_spurious: got request at %h, expected none", a);
                end else begin
                    ea = exp_addr_q.pop_front();
                    ew = exp_write_q.pop_front();
                    ed = exp_wdata_q.pop_front();
                    check("eng_addr", a, ea);
                    check("eng_write", w, ew);
                    if (ew) check("eng_wdata", eng_wdata, ed);
                    else check("eng_no_overflow", m_fifo.size() < DEPTH, 1);
                end
                addr_log.push_back(a);
                wdata_log.push_back(eng_wdata);
                n_issued++;
                d = $urandom_range(ack_max, 0);
                repeat (d) begin
                    @(negedge clk);
                    check("eng_req_hold", eng_req, 1);
                    check("eng_addr_hold", eng_addr, a);
                end
                eng_ack = 1;
                @(negedge clk);
                eng_ack = 0;
                check("eng_req_drop", eng_req, 0);
                if (n_issued == hang_at) begin
                    hung = 1;
                    wait (late_go);
                    @(negedge clk);
                    eng_rdata = 32'h0BAD0BAD; eng_done = 1;
                    @(negedge clk);
                    eng_done = 0; hung = 0; late_go = 0;
                end else begin
                    d = $urandom_range(done_max, 0);
                    repeat (d) @(negedge clk);
                    r = $urandom;
                    eng_rdata = r; eng_done = 1;
                    @(posedge clk);
                    #1;
                    if (!w) m_fifo.push_back(r);
                    n_done++;
                    @(negedge clk);
                    eng_done = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] prev, v;
        logic [23:0] ra;
        int base, lim, pops;
        bit ok, ir;

        // ---------------- reset ----------------
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs_zero("rst");
        reset = 1;
        @(negedge clk);
        bus_read(A_STATUS, "rst_status");
        check("rst_status_lit", data_out, 32'h2);

        // ---------------- basic read burst ----------------
        bus_write(A_CTRL, 32'h10);
        bus_write(A_ADDR, 32'h100);
        bus_write(A_LEN, 32'd3);
        addr_log.delete();
        bus_write(A_CTRL, 32'h11);
        wait_idle("t1_idle");
        check("t1_log0", addr_log[0], 24'h500100);
        check("t1_log1", addr_log[1], 24'h500104);
        check("t1_log2", addr_log[2], 24'h500108);
        for (int i = 0; i < 3; i++) bus_read(A_RDATA, "t1_rdata");
        bus_read(A_STATUS, "t1_status");
        check("t1_status_lit", data_out, 32'h2A);
        bus_read(A_ADDR, "t1_addr");
        check("t1_addr_lit", data_out, 32'h10C);
        @(negedge clk);
        check("t1_dout_hold", data_out, 32'h10C);
        check("t1_irq_on", irq, 1);
        bus_write(A_CTRL, 32'h0);
        check("t1_irq_off", irq, 0);
        bus_read(A_CTRL, "t1_ctrl");

        // ren and wen together act as a write; data_out keeps its value
        bus_read(A_LEN, "rw_len");
        prev = data_out;
        model_write(A_WDATA, 32'h1234_5678);
        ren = 1; wen = 1; address = A_WDATA; data_in = 32'h1234_5678;
        @(negedge clk);
        ren = 0; wen = 0;
        check("rw_hold", data_out, prev);
        bus_read(A_WDATA, "rw_wdata");
        bus_read(8'h18, "unmapped");

        // ---------------- FIFO full stall ----------------
        bus_write(A_CTRL, 32'h4);
        bus_write(A_ADDR, 32'h0);
        bus_write(A_LEN, 32'd12);
        base = n_issued;
        bus_write(A_CTRL, 32'h1);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (m_fifo.size() == DEPTH) begin ok = 1; break; end
            @(negedge clk);
        end
        check("t2_fill", ok, 1);
        repeat (10) begin
            @(negedge clk);
            check("t2_stall_req", eng_req, 0);
        end
        check("t2_issued8", n_issued - base, 8);
        bus_read(A_STATUS, "t2_status");
        check("t2_count_lit", data_out[15:8], 8);
        check("t2_full_lit", data_out[2], 1);
        bus_read(A_RDATA, "t2_pop");
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (m_fifo.size() == DEPTH) begin ok = 1; break; end
            @(negedge clk);
        end
        check("t2_refill", ok, 1);
        repeat (10) begin
            @(negedge clk);
            check("t2_stall_req2", eng_req, 0);
        end
        check("t2_issued9", n_issued - base, 9);
        for (int i = 0; i < 600; i++) begin
            if (n_issued - base == 12 && exp_addr_q.size() == 0 && m_fifo.size() == 0 && n_done >= base + 12)
                break;
            if (m_fifo.size() > 0) bus_read(A_RDATA, "t2_drain");
            else @(negedge clk);
        end
        wait_idle("t2_idle");
        bus_read(A_STATUS, "t2_status_end");
        bus_read(A_ADDR, "t2_addr");

        // ---------------- single write ----------------
        bus_write(A_CTRL, 32'h4);
        bus_write(A_WDATA, 32'hCAFEF00D);
        bus_write(A_ADDR, 32'h20);
        addr_log.delete(); wdata_log.delete();
        bus_write(A_CTRL, 32'h2);
        wait_idle("t3_idle");
        check("t3_nreq", addr_log.size(), 1);
        check("t3_addr_lit", addr_log[0], 24'h500020);
        check("t3_wdata_lit", wdata_log[0], 32'hCAFEF00D);
        bus_read(A_ADDR, "t3_addr");
        check("t3_addr_after", data_out, 32'h24);
        bus_read(A_STATUS, "t3_status");

        // ---------------- error cases ----------------
        bus_write(A_CTRL, 32'h4);
        bus_write(A_ADDR, 32'h40);
        bus_write(A_LEN, 32'd4);
        bus_write(A_CTRL, 32'h1);
        bus_write(A_CTRL, 32'h1);
        bus_write(A_ADDR, 32'h999);
        bus_write(A_CTRL, 32'h8);
        wait_idle("t4_idle");
        bus_read(A_ADDR, "t4_addr");
        bus_read(A_STATUS, "t4_status");
        for (int i = 0; i < 4; i++) bus_read(A_RDATA, "t4_rdata");
        base = n_issued;
        bus_write(A_CTRL, 32'h3);
        repeat (5) @(negedge clk);
        check("t4_no_traffic", n_issued, base);
        bus_read(A_RDATA, "t4_empty");
        check("t4_empty_lit", data_out, 32'hDEADBEEF);
        bus_read(A_STATUS, "t4_err");
        bus_write(A_CTRL, 32'h4);
        bus_read(A_STATUS, "t4_cleared");
        check("t4_cleared_lit", data_out[4:3], 0);
        bus_write(A_LEN, 32'd0);
        bus_write(A_CTRL, 32'h1);
        bus_read(A_STATUS, "t4_zero_len");
        check("t4_zero_len_lit", data_out[3:0], 4'b1010);
        bus_write(A_LEN, 32'd3);
        bus_write(A_CTRL, 32'h1);
        wait_idle("t4_fill_idle");
        bus_write(A_CTRL, 32'h8);
        bus_read(A_STATUS, "t4_flushed");

        // ---------------- wrap and reset mid-burst ----------------
        bus_write(A_LEN, 32'd0);
        bus_write(A_CTRL, 32'h15);
        check("t5_irq_pre", irq, m_done & m_irq_en);
        bus_write(A_ADDR, 32'hAFFFFC);
        bus_write(A_LEN, 32'd2);
        addr_log.delete();
        hang_at = n_issued + 2;
        bus_write(A_CTRL, 32'h11);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (hung) begin ok = 1; break; end
            @(negedge clk);
        end
        check("t5_hang", ok, 1);
        check("t5_wrap0_lit", addr_log[0], 24'hFFFFFC);
        check("t5_wrap1_lit", addr_log[1], 24'h000000);
        reset = 0;
        #1;
        check_outputs_zero("t5_rst");
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1;
        late_go = 1;
        repeat (6) begin
            @(negedge clk);
            check("t5_late_req", eng_req, 0);
        end
        bus_read(A_STATUS, "t5_status");
        check("t5_status_lit", data_out, 32'h2);
        hang_at = -1;

        // ---------------- randomized commands ----------------
        for (int it = 0; it < 12; it++) begin
            ack_max = $urandom_range(3, 0);
            done_max = $urandom_range(4, 0);
            ir = 1'($urandom_range(1, 0));
            bus_write(A_CTRL, {27'h0, ir, 4'hC});
            ra = 24'($urandom);
            bus_write(A_ADDR, {8'h0, ra});
            if ($urandom_range(3, 0) != 0) begin
                lim = $urandom_range(7, 0);
                bus_write(A_LEN, lim);
                bus_write(A_CTRL, {27'h0, ir, 4'h1});
                wait_idle("rnd_rd_idle");
                bus_read(A_STATUS, "rnd_status");
                pops = $urandom_range(lim + 1, 0);
                for (int p = 0; p < pops; p++) bus_read(A_RDATA, "rnd_rdata");
            end else begin
                v = $urandom;
                bus_write(A_WDATA, v);
                bus_write(A_CTRL, {27'h0, ir, 4'h2});
                wait_idle("rnd_wr_idle");
            end
            bus_read(A_ADDR, "rnd_addr");
            bus_read(A_STATUS, "rnd_status_end");
            check("rnd_irq", irq, m_done & m_irq_en);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/flash_burst_ctrl.md
Name: flash_burst_ctrl

Overview:
- Memory-mapped flash controller for the SoC peripheral bus, with register access over an 8-bit byte offset.
- Accepts read-burst and single-word write commands. It sequences one-word transactions to the SPI flash engine over a req/ack/done handshake.
- Read data is buffered in a parametrised FIFO. Status, sticky done/error flags and an interrupt are provided so software does not have to poll every word.

Parameters:
ADDR_W, 24, flash byte-address width; engine addresses wrap modulo 2^ADDR_W
BASE_OFFSET, 24'h500000, added to every software address before it is sent to the engine
FIFO_DEPTH, 8, read FIFO depth in 32-bit words; power of two, 2..64
LEN_W, 8, burst length register width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
ren  in  1  bus read strobe, one cycle per access
wen  in  1  bus write strobe, one cycle per access
address  in  8  register byte offset
data_in  in  32  bus write data
data_out  out  32  registered bus read data
irq  out  1  level interrupt, = done_flag & irq_en
eng_req  out  1  transaction request, held until eng_ack
eng_write  out  1  1 = write, 0 = read; stable while eng_req is high
eng_addr  out  ADDR_W  engine byte address; stable while eng_req is high
eng_wdata  out  32  engine write data
eng_ack  in  1  engine accepted the request (single-cycle pulse)
eng_done  in  1  transaction complete (single-cycle pulse)
eng_rdata  in  32  read word, valid with eng_done

Behaviour:
- Reset (async, reset==0):
  - All registers 0, FIFO empty, FSM IDLE.
  - data_out=0, irq=0, eng_req=0, eng_write=0, eng_addr=0, eng_wdata=0.
  - Reset mid-burst abandons the burst; a stray eng_done arriving after reset is ignored in IDLE.
- Bus:
  - Accesses are valid only when ren or wen is high. ren and wen together: treated as a write, data_out unchanged.
  - data_out updates on the clock edge after ren (1-cycle latency) and holds its value otherwise.
- Register map:
  - 0x00 STATUS (RO). Bit0 busy; bit1 fifo_empty; bit2 fifo_full; bit3 done_flag; bit4 err_flag; bit5 irq_en; bits[15:8] fifo count; other bits 0.
  - 0x04 CONTROL (W). Bit0 start read burst; bit1 start write; bit2 clear done_flag and err_flag; bit3 flush FIFO; bit4 irq_en (persistent, readable as 0x04 bit4).
  - 0x08 ADDRESS (RW). ADDR_W bits, zero-extended on read.
  - 0x0C WDATA (RW).
  - 0x10 RDATA (RO). Pops the FIFO.
  - 0x14 LENGTH (RW). LEN_W bits.
  - Any other offset: read returns 32'h0; write ignored.
- CONTROL write rules:
  - bit2 and bit3 apply the same cycle the write lands.
  - bit3 while busy is ignored and sets err_flag.
  - bit0 and bit1 both set, or either set while busy: command ignored, err_flag set.
  - bit0 with LENGTH==0: done_flag set next cycle; no engine traffic.
  - Writes to ADDRESS, WDATA or LENGTH while busy are ignored and set err_flag.
- FSM (busy = state != IDLE):
  - IDLE: on a start command, latch cnt=0 and go to ISSUE.
  - ISSUE: eng_req=1; eng_addr = BASE_OFFSET + ADDRESS + 4*cnt (mod 2^ADDR_W); eng_write/eng_wdata from the command and WDATA.
    - For reads, eng_req is asserted only if FIFO count < FIFO_DEPTH. Otherwise stall in ISSUE with eng_req=0 until a pop frees space, so the FIFO never overflows.
    - On eng_ack, drop eng_req and go to WAIT.
  - WAIT: on eng_done:
    - read: push eng_rdata to the FIFO; cnt++; if cnt==LENGTH go to FINISH, else go to ISSUE.
    - write: go to FINISH.
  - FINISH (1 cycle): ADDRESS += 4*LENGTH for reads, or += 4 for writes (mod 2^ADDR_W); done_flag=1; go to IDLE.
- FIFO:
  - Push and pop in the same cycle: count unchanged, data order preserved.
  - RDATA read when empty: data_out=32'hDEADBEEF, err_flag=1, count unchanged.
- done_flag and err_flag are sticky; only CONTROL bit2 or reset clears them. If clear and set occur in the same cycle, set wins.
- eng_ack or eng_done outside ISSUE/WAIT are ignored.

Test Plan:
- ADDRESS=0x100, LENGTH=3, CONTROL=1 -> eng_addr 0x500100, 0x500104, 0x500108 in order. Three RDATA reads return the engine words in order. Then STATUS bit3=1, ADDRESS reads 0x10C, and irq=1 only if irq_en was set.
- FIFO_DEPTH=8, LENGTH=12, no pops -> eng_req stays 0 after the 8th push and STATUS[15:8]=8, bit2=1. One RDATA pop -> exactly one further request issued.
- WDATA=0xCAFEF00D, ADDRESS=0x20, CONTROL=2 -> one request with eng_write=1, eng_addr 0x500020, eng_wdata 0xCAFEF00D. After done, ADDRESS=0x24.
- CONTROL=1 while busy, CONTROL=3 when idle, RDATA read when empty -> command ignored, err_flag=1, empty read returns 0xDEADBEEF. CONTROL=4 then clears STATUS bits3/4.
- ADDRESS=0xAFFFFC with BASE_OFFSET 0x500000, LENGTH=2 -> eng_addr 0xFFFFFC then 0x000000 (wrap). Assert reset while in WAIT -> all outputs 0 and FSM IDLE; the late eng_done is ignored and the FIFO count stays 0.
